// File: rtl/dct8_butterfly_in.sv
// dct8_butterfly_in
// Input stage of the 8-point DCT datapath. Serial residual samples of one row
// are gathered into a row buffer. The eighth sample is not stored: it is used
// straight from in_data to form the first even/odd butterfly. The four sums
// and four differences are then registered and flagged with a one-cycle
// out_valid pulse.
//
// Ports:
//   clk          single clock, rising edge
//   rst_b        synchronous active-low reset
//   in_valid     in_data carries a sample this cycle
//   in_first     sample is x0 of a new row (qualifies in_valid)
//   in_first_blk row is row 0 of a new block (qualifies in_valid and in_first)
//   in_data      signed sample, IN_WIDTH bits
//   in_ready     stage accepts samples
//   out_valid    one-cycle pulse, a0..a3 / b0..b3 / out_row are new
//   out_row      row index of the presented outputs within the 8x8 block
//   a0..a3       signed sums        ak = xk + x(7-k)
//   b0..b3       signed differences bk = xk - x(7-k)
//
// OUT_WIDTH is expected to be IN_WIDTH+1. That width holds any sum or
// difference exactly, so no saturation or rounding is needed.

module dct8_butterfly_in #(
   parameter int IN_WIDTH  = 18,
   parameter int OUT_WIDTH = 19
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_first_blk,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [2:0]           out_row,
   output logic [OUT_WIDTH-1:0] a0,
   output logic [OUT_WIDTH-1:0] a1,
   output logic [OUT_WIDTH-1:0] a2,
   output logic [OUT_WIDTH-1:0] a3,
   output logic [OUT_WIDTH-1:0] b0,
   output logic [OUT_WIDTH-1:0] b1,
   output logic [OUT_WIDTH-1:0] b2,
   output logic [OUT_WIDTH-1:0] b3
);

   typedef enum logic {IDLE, FILL} state_t;

   state_t               state, stateNext;
   logic [2:0]           cnt, cntNext;
   logic                 accept, loadFirst, complete;
   logic                 readyArm;
   logic                 blkFlag;
   logic [2:0]           rowNext;
   logic [2:0]           rowDone;
   logic [IN_WIDTH-1:0]  x [0:6];
   logic [OUT_WIDTH-1:0] sum  [0:3];
   logic [OUT_WIDTH-1:0] diff [0:3];

   function automatic logic [OUT_WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] v);
      return {{(OUT_WIDTH-IN_WIDTH){v[IN_WIDTH-1]}}, v};
   endfunction

   assign accept = in_valid && in_ready;

   // State and sample counter register.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next-state logic. in_first always restarts a row, even when cnt is 7.
   // That silently drops any partial row. A sample that arrives in IDLE
   // without in_first also starts a row, so a free-running stream still
   // lines up.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      loadFirst = 1'b0;
      complete  = 1'b0;
      if (accept) begin
         if (in_first || state == IDLE) begin
            loadFirst = 1'b1;
            cntNext   = 3'd1;
            stateNext = FILL;
         end else if (cnt == 3'd7) begin
            complete  = 1'b1;
            cntNext   = 3'd0;
            stateNext = IDLE;
         end else begin
            cntNext   = cnt + 3'd1;
         end
      end
   end

   // Butterfly. x7 is the incoming sample, so the result registers on the
   // same edge that accepts it.
   always_comb begin
      sum[0]  = sext(x[0]) + sext(in_data);
      diff[0] = sext(x[0]) - sext(in_data);
      for (int k = 1; k < 4; k++) begin
         sum[k]  = sext(x[k]) + sext(x[7-k]);
         diff[k] = sext(x[k]) - sext(x[7-k]);
      end
   end

   // A row whose x0 carried in_first_blk is forced to row 0. Later rows
   // count on from there.
   assign rowDone = blkFlag ? 3'd0 : rowNext;

   // Datapath registers. in_ready rises only on the second edge after reset
   // is released, through the two-stage readyArm/in_ready chain.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         readyArm  <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_row   <= 3'd0;
         rowNext   <= 3'd0;
         blkFlag   <= 1'b0;
         for (int i = 0; i < 7; i++) x[i] <= '0;
         a0 <= '0; a1 <= '0; a2 <= '0; a3 <= '0;
         b0 <= '0; b1 <= '0; b2 <= '0; b3 <= '0;
      end else begin
         readyArm  <= 1'b1;
         in_ready  <= readyArm;
         out_valid <= complete;
         if (loadFirst) begin
            x[0]    <= in_data;
            blkFlag <= in_first && in_first_blk;
         end else if (accept && !complete) begin
            for (int i = 1; i < 7; i++) begin
               if (cnt == 3'(i)) x[i] <= in_data;
            end
         end
         if (complete) begin
            a0 <= sum[0];  a1 <= sum[1];  a2 <= sum[2];  a3 <= sum[3];
            b0 <= diff[0]; b1 <= diff[1]; b2 <= diff[2]; b3 <= diff[3];
            out_row <= rowDone;
            rowNext <= rowDone + 3'd1;
         end
      end
   end

endmodule
